div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have reset rst, synchronous, active-high.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 The block SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 The block SHALL have port opdata1_i  input  32  dividend.
REQ-006 The block SHALL have port opdata2_i  input  32  divisor.
REQ-007 The block SHALL have port start_i  input  1  division request, held high by EX until ready_o is seen.
REQ-008 The block SHALL have port annul_i  input  1  cancel the in-flight division (pipeline flush).
REQ-009 The block SHALL have port result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 The block SHALL have port ready_o  output  1  result_o valid.

Function
REQ-011 The block SHALL implement a four-state FSM: FREE, BYZERO, ON, END; all outputs SHALL be registered.
REQ-012 FREE, start_i=1, annul_i=0, opdata2_i=0: next state SHALL be BYZERO.
REQ-013 FREE, start_i=1, annul_i=0, opdata2_i!=0: next state ON, cnt=0; latch signed_div_i, opdata1_i[31], opdata2_i[31].
REQ-014 FREE entry SHALL also load the 65-bit working register as {32'b0, |op1|, 1'b0} and the divisor register as |op2|; |x| = two's-complement negation only when signed and x[31]=1, else x unchanged.
REQ-015 FREE with start_i=0 or annul_i=1: state SHALL remain FREE, ready_o=0, result_o=0.
REQ-016 BYZERO SHALL clear the working register and go to END on the next edge, giving result_o=0.
REQ-017 ON, cnt<32, annul_i=0: one restoring step per edge; diff = {1'b0, work[63:32]} - {1'b0, divisor} (33 bits).
REQ-018 Restoring step, diff[32]=1: work <= {work[63:0], 1'b0}; else work <= {diff[31:0], work[31:0], 1'b1}; cnt increments.
REQ-019 ON, cnt=32: quotient = work[31:0] and remainder = work[64:33].
REQ-020 ON, cnt=32: quotient SHALL be negated if latched signed and op1 sign XOR op2 sign = 1.
REQ-021 ON, cnt=32: remainder SHALL be negated if latched signed and op1 sign = 1.
REQ-022 ON, cnt=32: result_o <= {remainder, quotient}, ready_o <= 1, state END.
REQ-023 ON with annul_i=1 SHALL return to FREE on that edge, with ready_o=0 and result_o=0; the partial result SHALL be discarded.
REQ-024 END, start_i=1: result_o and ready_o=1 SHALL be held.
REQ-025 END, start_i=0: next state FREE, ready_o=0, result_o=0.
REQ-026 Latency for nonzero divisor: ready_o SHALL assert on the 34th rising edge counting the start-sampling edge as 1.
REQ-027 Latency for divide by zero: ready_o SHALL assert on the 2nd rising edge.
REQ-028 Operand changes after the start-sampling edge SHALL NOT affect the result; only latched values SHALL be used.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF SHALL wrap: quotient 0x80000000, remainder 0, with no exception signalled.
REQ-030 start_i=1 and annul_i=1 on the same FREE edge: annul SHALL take priority and no division starts.

Reset
REQ-031 rst=1 at an edge SHALL force state FREE, with cnt, working register, divisor register, result_o and ready_o all 0, regardless of state, including mid-ON.
REQ-032 After rst deasserts, the first start_i SHALL be accepted normally.

Verification
REQ-033 Unsigned 7/2, start held -> ready_o at edge 34, result_o=0x00000001_00000003.
REQ-034 Signed -7/2 (0xFFFFFFF9, 2) -> result_o=0xFFFFFFFF_FFFFFFFD; unsigned 0xFFFFFFF9/2 -> 0x00000001_7FFFFFFC.
REQ-035 Divisor 0, any dividend -> ready_o at edge 2, result_o=0; drop start_i -> next edge ready_o=0.
REQ-036 annul_i pulse at step 10 -> ready_o never asserts, FREE next edge; new 100/7 start -> 0x00000002_0000000E at edge 34.
REQ-037 rst asserted at step 20 -> all outputs 0 next edge; subsequent 0x80000000/0xFFFFFFFF signed -> 0x00000000_80000000.
REQ-038 Change opdata1_i/opdata2_i/signed_div_i every cycle after the start edge -> result matches the operands captured at start.

Source files
------------

// File: rtl/div.sv
// ============================================================================
// Module   : div
// Purpose  : 32-bit signed/unsigned restoring divider; one quotient bit per
//            cycle, result packed as {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    localparam logic [5:0] C_STEPS  = 6'd32;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_work;
    logic [31:0] r_divisor;
    logic        r_signed;
    logic        r_op1_neg;
    logic        r_op2_neg;

    logic [1:0]  w_state_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [64:0] w_work_nxt;
    logic [31:0] w_divisor_nxt;
    logic        w_signed_nxt;
    logic        w_op1_neg_nxt;
    logic        w_op2_neg_nxt;
    logic [63:0] w_result_nxt;
    logic        w_ready_nxt;

    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;
    logic [32:0] w_diff;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // Magnitudes are taken from the live operands: they are only consumed on
    // the start-sampling edge, after which the latched copies are used.
    assign w_op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign w_op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_divisor};

    assign w_quot = (r_signed && (r_op1_neg ^ r_op2_neg)) ? (~r_work[31:0] + 32'd1)
                                                           : r_work[31:0];
    assign w_rem  = (r_signed && r_op1_neg) ? (~r_work[64:33] + 32'd1) : r_work[64:33];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_work_nxt    = r_work;
        w_divisor_nxt = r_divisor;
        w_signed_nxt  = r_signed;
        w_op1_neg_nxt = r_op1_neg;
        w_op2_neg_nxt = r_op2_neg;
        w_result_nxt  = result_o;
        w_ready_nxt   = ready_o;

        case (r_state)
            S_FREE: begin
                w_ready_nxt  = 1'b0;
                w_result_nxt = 64'd0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        w_state_nxt = S_BYZERO;
                    end else begin
                        w_state_nxt   = S_ON;
                        w_cnt_nxt     = 6'd0;
                        w_signed_nxt  = signed_div_i;
                        w_op1_neg_nxt = opdata1_i[31];
                        w_op2_neg_nxt = opdata2_i[31];
                        w_work_nxt    = {32'd0, w_op1_abs, 1'b0};
                        w_divisor_nxt = w_op2_abs;
                    end
                end
            end

            S_BYZERO: begin
                w_work_nxt   = 65'd0;
                w_result_nxt = 64'd0;
                w_ready_nxt  = 1'b1;
                w_state_nxt  = S_END;
            end

            S_ON: begin
                if (annul_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = 64'd0;
                end else if (r_cnt != C_STEPS) begin
                    // Borrow out means the divisor did not fit: shift in a 0.
                    if (w_diff[32]) begin
                        w_work_nxt = {r_work[63:0], 1'b0};
                    end else begin
                        w_work_nxt = {w_diff[31:0], r_work[31:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    w_result_nxt = {w_rem, w_quot};
                    w_ready_nxt  = 1'b1;
                    w_state_nxt  = S_END;
                end
            end

            S_END: begin
                if (!start_i) begin
                    w_state_nxt  = S_FREE;
                    w_ready_nxt  = 1'b0;
                    w_result_nxt = 64'd0;
                end
            end

            default: begin
                w_state_nxt  = S_FREE;
                w_ready_nxt  = 1'b0;
                w_result_nxt = 64'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FREE;
            r_cnt     <= 6'd0;
            r_work    <= 65'd0;
            r_divisor <= 32'd0;
            r_signed  <= 1'b0;
            r_op1_neg <= 1'b0;
            r_op2_neg <= 1'b0;
            result_o  <= 64'd0;
            ready_o   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_work    <= w_work_nxt;
            r_divisor <= w_divisor_nxt;
            r_signed  <= w_signed_nxt;
            r_op1_neg <= w_op1_neg_nxt;
            r_op2_neg <= w_op2_neg_nxt;
            result_o  <= w_result_nxt;
            ready_o   <= w_ready_nxt;
        end
    end

endmodule

`default_nettype wire
